// File: rtl/mdu_ctrl_pkg.sv
// Shared op encodings, default latencies and op classification helpers for the MDU.
package mdu_ctrl_pkg;

    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } mdu_op_e;

    // Stall looks ahead on the whole arithmetic group regardless of build options.
    function automatic logic isArithOp(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Pipeline-side bundle for the MDU: E-stage request, D-stage hazard hint, status and HI/LO.
interface mdu_ctrl_if;

    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_md_use;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_val, rt_val, d_md_use,
        input  busy, stall, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, d_md_use,
        output busy, stall, hi, lo
    );

endinterface

// File: rtl/mdu_ctrl_alu.sv
// Combinational MDU arithmetic (mdu_alu): 64-bit {hi, lo} from latched operands.
// The divider is only present when MDU_DIV_EN is defined.
module mdu_alu
    import mdu_ctrl_pkg::*;
(
    input  logic [31:0] i_rs,
    input  logic [31:0] i_rt,
    input  logic [2:0]  i_op,
    output logic [63:0] o_res
);

    logic [63:0] w_sProd;
    logic [63:0] w_uProd;

    assign w_sProd = {{32{i_rs[31]}}, i_rs} * {{32{i_rt[31]}}, i_rt};
    assign w_uProd = {32'd0, i_rs} * {32'd0, i_rt};

`ifdef MDU_DIV_EN
    // One unsigned divider on magnitudes; signs are restored afterwards, so
    // INT_MIN / -1 wraps to INT_MIN instead of trapping.
    logic        w_negA;
    logic        w_negB;
    logic [31:0] w_magA;
    logic [31:0] w_magB;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_negA = (i_op == OP_DIV) && i_rs[31];
    assign w_negB = (i_op == OP_DIV) && i_rt[31];
    assign w_magA = w_negA ? -i_rs : i_rs;
    assign w_magB = (i_rt == 32'd0) ? 32'd1 : (w_negB ? -i_rt : i_rt);
    assign w_q    = w_magA / w_magB;
    assign w_r    = w_magA % w_magB;
    assign w_quot = (w_negA ^ w_negB) ? -w_q : w_q;
    assign w_rem  = w_negA ? -w_r : w_r;
`endif

    always_comb begin
        o_res = 64'd0;
        case (i_op)
            OP_MULT:  o_res = w_sProd;
            OP_MULTU: o_res = w_uProd;
`ifdef MDU_DIV_EN
            OP_DIV,
            OP_DIVU:  o_res = {w_rem, w_quot};
`endif
            default:  o_res = 64'd0;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: IDLE/RUN FSM, latency down-counter, HI/LO registers and pipeline stall.
// Define MDU_DIV_EN to enable DIV/DIVU; otherwise they behave as no-ops.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
)
(
    input  logic       clk,
    input  logic       reset,
    mdu_ctrl_if.slave  bus
);

    localparam int CNT_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [CW-1:0] MULT_LAT = CW'(MULT_CYC);

    logic [0:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_op;
    logic [31:0]   r_rs;
    logic [31:0]   r_rt;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;

    logic          w_isMul;
    logic          w_isDiv;
    logic          w_divZero;
    logic [CW-1:0] w_lat;
    logic [63:0]   w_res;

    assign w_isMul = (bus.op == OP_MULT) || (bus.op == OP_MULTU);

`ifdef MDU_DIV_EN
    localparam logic [CW-1:0] DIV_LAT = CW'(DIV_CYC);
    assign w_isDiv   = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    assign w_divZero = ((r_op == OP_DIV) || (r_op == OP_DIVU)) && (r_rt == 32'd0);
    assign w_lat     = w_isMul ? MULT_LAT : DIV_LAT;
`else
    assign w_isDiv   = 1'b0;
    assign w_divZero = 1'b0;
    assign w_lat     = MULT_LAT;
`endif

    mdu_alu u_alu (
        .i_rs  (r_rs),
        .i_rt  (r_rt),
        .i_op  (r_op),
        .o_res (w_res)
    );

    // Requests are only looked at in IDLE; a divide by zero burns its cycles but keeps HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= OP_NONE;
            r_rs    <= '0;
            r_rt    <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CW'(1)) begin
                r_state <= S_IDLE;
                if (!w_divZero) begin
                    r_hi <= w_res[63:32];
                    r_lo <= w_res[31:0];
                end
            end
        end else if (bus.start) begin
            if (w_isMul || w_isDiv) begin
                r_state <= S_RUN;
                r_cnt   <= w_lat;
                r_op    <= bus.op;
                r_rs    <= bus.rs_val;
                r_rt    <= bus.rt_val;
            end else if (bus.op == OP_MTHI) begin
                r_hi <= bus.rs_val;
            end else if (bus.op == OP_MTLO) begin
                r_lo <= bus.rs_val;
            end
        end
    end

    assign bus.busy  = (r_state == S_RUN);
    assign bus.stall = bus.d_md_use & (bus.busy | (bus.start & isArithOp(bus.op)));
    assign bus.hi    = r_hi;
    assign bus.lo    = r_lo;

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameters: MULT_CYC, default 5, multiply latency in cycles; DIV_CYC, default 10, divide latency in cycles.
REQ-002 SHALL have port clk, input, 1, single clock, rising-edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high.
REQ-004 SHALL have port start, input, 1, E-stage MDU instruction valid this cycle.
REQ-005 SHALL have port op, input, 3, MDU operation code (see REQ-030).
REQ-006 SHALL have port rs_val, input, 32, forwarded rs operand.
REQ-007 SHALL have port rt_val, input, 32, forwarded rt operand.
REQ-008 SHALL have port d_md_use, input, 1, D-stage instruction is any MDU op (mult/multu/div/divu/mthi/mtlo/mfhi/mflo).
REQ-009 SHALL have port busy, output, 1, arithmetic operation in progress.
REQ-010 SHALL have port stall, output, 1, freeze F/D and bubble E.
REQ-011 SHALL have port hi, output, 32, HI register.
REQ-012 SHALL have port lo, output, 32, LO register.

Function
REQ-013 SHALL implement FSM states IDLE and RUN, with a down-counter cnt of width sufficient for max(MULT_CYC, DIV_CYC).
REQ-014 SHALL accept start only in IDLE; start while in RUN SHALL be ignored, with no state, operand or HI/LO change.
REQ-015 On an accepted start with op MULT/MULTU/DIV/DIVU at edge k, SHALL latch rs_val, rt_val and op, load cnt with the latency, and enter RUN.
REQ-016 In RUN, cnt SHALL decrement each edge; at the edge where cnt goes 1->0 the block SHALL write HI/LO and return to IDLE.
REQ-017 busy SHALL equal (state==RUN); it SHALL be high for exactly MULT_CYC or DIV_CYC cycles after the accepting edge.
REQ-018 MULT SHALL produce the signed 64-bit product and MULTU the unsigned 64-bit product; HI gets [63:32] and LO gets [31:0].
REQ-019 DIV/DIVU SHALL produce LO = quotient and HI = remainder, signed or unsigned respectively; a signed remainder SHALL take the sign of the dividend.
REQ-020 Divide with rt_val==0 SHALL still take DIV_CYC cycles and SHALL leave HI/LO unchanged.
REQ-021 An accepted MTHI/MTLO SHALL write rs_val to HI/LO at edge k, SHALL not enter RUN, and SHALL not assert busy.
REQ-022 op NONE or unknown codes with start SHALL be a no-op.
REQ-023 stall SHALL be combinational: d_md_use & (busy | (start & op in {MULT, MULTU, DIV, DIVU})).
REQ-024 hi/lo SHALL be registered outputs and SHALL change only per REQ-016, REQ-020 and REQ-021.

Reset
REQ-025 reset at any edge, including mid-RUN, SHALL force IDLE, cnt=0, busy=0, hi=0, lo=0, and discard latched operands.
REQ-026 start asserted in the same cycle as reset SHALL be ignored.

Configuration
REQ-027 Macro MDU_DIV_EN defined SHALL compile in the DIV/DIVU datapath and behaviour per REQ-019 and REQ-020.
REQ-028 Without MDU_DIV_EN, DIV/DIVU SHALL be treated as no-ops per REQ-022 and no divider logic SHALL be synthesized.

Structure
REQ-029 A shared package/header SHALL hold the op encodings and the default latency constants.
REQ-030 Op encodings SHALL be: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
REQ-031 The arithmetic SHALL live in one combinational sub-module, mdu_alu (operands, op -> 64-bit {hi, lo}); the FSM, counter and HI/LO registers SHALL be in mdu_ctrl.

Verification
REQ-032 MULT with rs=0xFFFFFFFE, rt=3: busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU with the same operands: hi=0x00000002, lo=0xFFFFFFFA.
REQ-033 DIV with rs=-7, rt=2: busy high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV with rt=0: HI/LO unchanged after 10 cycles.
REQ-034 MTHI with rs=0x12345678 in IDLE: hi=0x12345678 next cycle, busy never asserted; MTHI during RUN: ignored.
REQ-035 d_md_use=1 held during MULT: stall high from the start cycle through the last busy cycle; with d_md_use=0, stall stays low.
REQ-036 reset asserted on cycle 3 of a DIV: busy=0, hi=lo=0 next cycle; a new MULT accepted immediately after completes normally.
REQ-037 Without MDU_DIV_EN, DIV start: busy stays 0 and hi/lo are unchanged.
